// File: rtl/instmem_pkg.sv
// Shared types and constants for the programmable instruction memory.
package instmem_pkg;

  localparam int INSTMEM_DATA_W = 32;

  // addi x0, x0, 0 -- the canonical RV32I no-op, used as fill and fault word
  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

  // Ceiling log2 for sizing word-index fields from a word count
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/instmem_array.sv
// One-write / one-read word storage with optional registered read port.
module instmem_array #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int AW       = 5,
  parameter int REG_READ = 0
) (
  input  logic              clock,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage is deliberately not reset; the clear sweep in the top level fills it
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  generate
    if (REG_READ != 0) begin : g_reg_read
      // Synchronous read so the array can map onto block RAM
      always_ff @(posedge clock) begin
        rdata <= mem[raddr];
      end
    end else begin : g_comb_read
      assign rdata = mem[raddr];
    end
  endgenerate

endmodule

// File: rtl/instmem_prog.sv
// Instruction memory with checked byte-addressed fetch and a streaming program-load port.
module instmem_prog
  import instmem_pkg::*;
#(
  parameter int                DATA_W         = INSTMEM_DATA_W,
  parameter int                DEPTH          = 32,
  parameter logic [DATA_W-1:0] NOP_WORD       = DATA_W'(RV_NOP),
  parameter int                REG_READ       = 0,
  parameter int                CLEAR_ON_RESET = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       fetch_addr,
  output logic [DATA_W-1:0] fetch_instr,
  output logic              fetch_valid,
  output logic              fetch_fault,
  input  logic              load_start,
  input  logic [31:0]       load_base,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              load_done,
  output logic              load_err,
  output logic              busy
);

  localparam int            AW          = clog2(DEPTH);
  localparam logic [AW-1:0] LAST_IDX    = AW'(DEPTH - 1);
  localparam state_t        RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

  generate
    if (DATA_W != 32) begin : g_bad_data_w
      $error("instmem_prog: DATA_W must be 32 for RV32");
    end
    if (DEPTH < 2 || (1 << AW) != DEPTH || AW > 29) begin : g_bad_depth
      $error("instmem_prog: DEPTH must be a power of two between 2 and 2**29");
    end
  endgenerate

  state_t            state, state_n;
  logic [AW-1:0]     ptr, ptr_n;
  logic              done_q, done_n;
  logic              err_q, err_n;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic [AW-1:0] fetch_idx;
  logic          fetch_bad;
  logic [AW-1:0] base_idx;
  logic          base_bad;

  assign fetch_idx = fetch_addr[AW+1:2];
  assign fetch_bad = (|fetch_addr[1:0]) | (|fetch_addr[31:AW+2]);
  assign base_idx  = load_base[AW+1:2];
  assign base_bad  = (|load_base[1:0]) | (|load_base[31:AW+2]);

  instmem_array #(
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .AW      (AW),
    .REG_READ(REG_READ)
  ) u_array (
    .clock(clock),
    .we   (mem_we),
    .waddr(ptr),
    .wdata(mem_wdata),
    .raddr(fetch_idx),
    .rdata(mem_rdata)
  );

  // State, write pointer and the one-cycle done/error pulses
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= RESET_STATE;
      ptr    <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_n;
      ptr    <= ptr_n;
      done_q <= done_n;
      err_q  <= err_n;
    end
  end

  // Clear sweep, burst start validation and load handshake
  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    mem_we    = 1'b0;
    mem_wdata = load_data;
    done_n    = 1'b0;
    err_n     = 1'b0;
    case (state)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_wdata = NOP_WORD;
        ptr_n     = ptr + AW'(1);
        if (ptr == LAST_IDX) begin
          ptr_n   = '0;
          state_n = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (load_start) begin
          if (base_bad) begin
            err_n = 1'b1;
          end else begin
            ptr_n   = base_idx;
            state_n = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (load_valid) begin
          mem_we = 1'b1;
          ptr_n  = ptr + AW'(1);
          if (load_last) begin
            done_n  = 1'b1;
            state_n = ST_IDLE;
          end else if (ptr == LAST_IDX) begin
            err_n   = 1'b1;
            state_n = ST_IDLE;
          end
        end
      end
      default: state_n = RESET_STATE;
    endcase
  end

  assign load_ready = (state == ST_LOAD);
  assign busy       = (state != ST_IDLE);
  assign load_done  = done_q;
  assign load_err   = err_q;

  generate
    if (REG_READ != 0) begin : g_fetch_reg
      logic valid_q;
      logic fault_q;

      // Valid and fault travel one cycle alongside the registered read data
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          valid_q <= 1'b0;
          fault_q <= 1'b0;
        end else begin
          valid_q <= (state == ST_IDLE);
          fault_q <= fetch_bad;
        end
      end

      assign fetch_valid = valid_q;
      assign fetch_fault = fault_q;
      assign fetch_instr = (valid_q && !fault_q) ? mem_rdata : NOP_WORD;
    end else begin : g_fetch_comb
      assign fetch_valid = (state == ST_IDLE);
      assign fetch_fault = fetch_bad;
      assign fetch_instr = (fetch_valid && !fetch_bad) ? mem_rdata : NOP_WORD;
    end
  endgenerate

endmodule

// File: tb/tb_instmem_prog.sv
// Randomised self-checking bench: combinational-read and registered-read instances share stimulus.
module tb_instmem_prog;

  localparam int          DEPTH = 32;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] fetch_addr = '0;
  logic        load_start = 1'b0;
  logic [31:0] load_base = '0;
  logic        load_valid = 1'b0;
  logic [31:0] load_data = '0;
  logic        load_last = 1'b0;

  logic [31:0] c_instr, r_instr;
  logic        c_valid, c_fault, r_valid, r_fault;
  logic        ready0, done0, err0, busy0;
  logic        ready1, done1, err1, busy1;

  int n_cmp = 0;
  int n_fail = 0;

  logic [31:0] model_mem [DEPTH];
  logic [31:0] burst_data [8];
  logic [31:0] fetch_q [$];

  instmem_prog #(.DEPTH(DEPTH), .REG_READ(0)) dut0 (
    .clock(clock), .reset(reset),
    .fetch_addr(fetch_addr), .fetch_instr(c_instr), .fetch_valid(c_valid), .fetch_fault(c_fault),
    .load_start(load_start), .load_base(load_base), .load_valid(load_valid),
    .load_data(load_data), .load_last(load_last),
    .load_ready(ready0), .load_done(done0), .load_err(err0), .busy(busy0)
  );

  instmem_prog #(.DEPTH(DEPTH), .REG_READ(1)) dut1 (
    .clock(clock), .reset(reset),
    .fetch_addr(fetch_addr), .fetch_instr(r_instr), .fetch_valid(r_valid), .fetch_fault(r_fault),
    .load_start(load_start), .load_base(load_base), .load_valid(load_valid),
    .load_data(load_data), .load_last(load_last),
    .load_ready(ready1), .load_done(done1), .load_err(err1), .busy(busy1)
  );

  // Free-running clock
  always #5 clock = ~clock;

  // Hard stop in case some wait never completes
  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout got=running exp=finished");
    $fatal(1, "[TB] timeout");
  end

  // Reference rules: a fetch faults when misaligned or beyond the last word
  function automatic logic exp_fault(input logic [31:0] a);
    return (a % 4 != 0) || ((a / 4) >= 32'(DEPTH));
  endfunction

  function automatic logic [31:0] exp_instr(input logic [31:0] a);
    if (exp_fault(a)) return NOP;
    return model_mem[int'(a / 4)];
  endfunction

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 3))
      0:       return 32'($urandom_range(0, DEPTH - 1)) * 4;
      1:       return 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(1, 3));
      2:       return $urandom;
      default: return 32'(DEPTH * 4) + 32'($urandom_range(0, 255));
    endcase
  endfunction

  // Reset has just been released at this negedge: expect a DEPTH-cycle busy sweep then NOP everywhere
  task automatic run_clear(input string tag);
    int cnt;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = NOP;
    fetch_addr = 32'h40;
    cnt = 0;
    #1;
    while (busy0 === 1'b1 && cnt < 200) begin
      cnt++;
      @(negedge clock);
      #1;
    end
    n_cmp++;
    if (cnt != DEPTH) begin
      n_fail++;
      $display("[TB] FAIL %s_clear_cycles got=%0d exp=%0d", tag, cnt, DEPTH);
    end
    n_cmp++;
    if ({c_valid, c_fault, c_instr} !== {1'b1, 1'b0, NOP}) begin
      n_fail++;
      $display("[TB] FAIL %s_comb_after_clear got=%b/%b/%h exp=1/0/%h", tag, c_valid, c_fault, c_instr, NOP);
    end
    n_cmp++;
    if (r_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL %s_reg_valid_early got=%b exp=0", tag, r_valid);
    end
    @(negedge clock);
    #1;
    n_cmp++;
    if ({r_valid, r_fault, r_instr} !== {1'b1, 1'b0, NOP}) begin
      n_fail++;
      $display("[TB] FAIL %s_reg_after_clear got=%b/%b/%h exp=1/0/%h", tag, r_valid, r_fault, r_instr, NOP);
    end
  endtask

  // Present the queued addresses one per cycle; the registered instance must lag by one cycle
  task automatic fetch_seq(input string tag);
    logic [31:0] a, prev;
    bit have_prev;
    have_prev = 1'b0;
    prev = '0;
    while (fetch_q.size() > 0) begin
      a = fetch_q.pop_front();
      @(negedge clock);
      fetch_addr = a;
      #1;
      n_cmp++;
      if ({c_valid, c_fault, c_instr} !== {1'b1, exp_fault(a), exp_instr(a)}) begin
        n_fail++;
        $display("[TB] FAIL %s_comb_fetch addr=%h got=%b/%b/%h exp=1/%b/%h",
                 tag, a, c_valid, c_fault, c_instr, exp_fault(a), exp_instr(a));
      end
      if (have_prev) begin
        n_cmp++;
        if ({r_valid, r_fault, r_instr} !== {1'b1, exp_fault(prev), exp_instr(prev)}) begin
          n_fail++;
          $display("[TB] FAIL %s_reg_fetch addr=%h got=%b/%b/%h exp=1/%b/%h",
                   tag, prev, r_valid, r_fault, r_instr, exp_fault(prev), exp_instr(prev));
        end
      end
      prev = a;
      have_prev = 1'b1;
    end
    @(negedge clock);
    #1;
    if (have_prev) begin
      n_cmp++;
      if ({r_valid, r_fault, r_instr} !== {1'b1, exp_fault(prev), exp_instr(prev)}) begin
        n_fail++;
        $display("[TB] FAIL %s_reg_fetch_tail addr=%h got=%b/%b/%h exp=1/%b/%h",
                 tag, prev, r_valid, r_fault, r_instr, exp_fault(prev), exp_instr(prev));
      end
    end
  endtask

  // Start a burst and stream nwords from burst_data with random stalls, checking the handshake
  task automatic run_burst(input string tag, input logic [31:0] base, input int nwords, input bit last_on_final);
    bit bad, active, is_last, ending;
    int widx, stalls;
    bad = (base % 4 != 0) || ((base / 4) >= 32'(DEPTH));
    @(negedge clock);
    load_start = 1'b1;
    load_base  = base;
    @(negedge clock);
    load_start = 1'b0;
    load_base  = $urandom;
    #1;
    n_cmp++;
    if ({err0, ready0, done0} !== {bad, !bad, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL %s_start base=%h got err/ready/done=%b%b%b exp=%b%b0", tag, base, err0, ready0, done0, bad, !bad);
    end
    if (bad) begin
      @(negedge clock);
      #1;
      n_cmp++;
      if ({err0, busy0} !== 2'b00) begin
        n_fail++;
        $display("[TB] FAIL %s_err_pulse got err/busy=%b%b exp=00", tag, err0, busy0);
      end
      return;
    end
    widx   = int'(base / 4);
    active = 1'b1;
    for (int i = 0; i < nwords; i++) begin
      stalls = active ? $urandom_range(0, 2) : 0;
      repeat (stalls) begin
        @(negedge clock);
        #1;
        n_cmp++;
        if ({ready0, done0, err0} !== 3'b100) begin
          n_fail++;
          $display("[TB] FAIL %s_stall got ready/done/err=%b%b%b exp=100", tag, ready0, done0, err0);
        end
      end
      is_last    = last_on_final && (i == nwords - 1);
      load_valid = 1'b1;
      load_data  = burst_data[i];
      load_last  = is_last;
      if (active) model_mem[widx] = burst_data[i];
      @(negedge clock);
      load_valid = 1'b0;
      load_last  = 1'b0;
      #1;
      if (active) begin
        ending = is_last || (widx == DEPTH - 1);
        n_cmp++;
        if ({done0, err0, ready0} !== {is_last, !is_last && (widx == DEPTH - 1), !ending}) begin
          n_fail++;
          $display("[TB] FAIL %s_xfer idx=%0d got done/err/ready=%b%b%b exp=%b%b%b", tag, widx,
                   done0, err0, ready0, is_last, !is_last && (widx == DEPTH - 1), !ending);
        end
        widx++;
        if (ending) active = 1'b0;
      end else begin
        n_cmp++;
        if ({ready0, done0, err0} !== 3'b000) begin
          n_fail++;
          $display("[TB] FAIL %s_after_end got ready/done/err=%b%b%b exp=000", tag, ready0, done0, err0);
        end
      end
    end
    if (!active) begin
      @(negedge clock);
      #1;
      n_cmp++;
      if ({done0, err0, busy0} !== 3'b000) begin
        n_fail++;
        $display("[TB] FAIL %s_pulse_width got done/err/busy=%b%b%b exp=000", tag, done0, err0, busy0);
      end
    end
  endtask

  // Reset values, clear sweep length, and a reset that interrupts the sweep
  task automatic test_reset();
    @(negedge clock);
    #1;
    n_cmp++;
    if ({busy0, ready0, done0, err0, c_valid, r_valid, r_fault} !== 7'b1000000) begin
      n_fail++;
      $display("[TB] FAIL reset_flags got=%b%b%b%b%b%b%b exp=1000000", busy0, ready0, done0, err0, c_valid, r_valid, r_fault);
    end
    n_cmp++;
    if ({c_instr, r_instr} !== {NOP, NOP}) begin
      n_fail++;
      $display("[TB] FAIL reset_instr got=%h/%h exp=%h/%h", c_instr, r_instr, NOP, NOP);
    end
    @(negedge clock);
    reset = 1'b0;
    repeat (10) @(negedge clock);
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({busy0, c_valid} !== 2'b10) begin
      n_fail++;
      $display("[TB] FAIL reset_mid_clear got busy/valid=%b%b exp=10", busy0, c_valid);
    end
    @(negedge clock);
    reset = 1'b0;
    run_clear("reset");
    for (int i = 0; i < 8; i++) fetch_q.push_back(32'($urandom_range(0, DEPTH - 1)) * 4);
    fetch_seq("reset_nop");
  endtask

  // Basic three-word burst at 0x8
  task automatic test_load_basic();
    burst_data[0] = 32'h00A2_00B3;
    burst_data[1] = 32'h4012_0133;
    burst_data[2] = 32'h0000_0073;
    run_burst("basic", 32'h8, 3, 1'b1);
    fetch_q.push_back(32'h8);
    fetch_q.push_back(32'hC);
    fetch_q.push_back(32'h10);
    fetch_q.push_back(32'h4);
    fetch_q.push_back(32'h14);
    fetch_seq("basic");
  endtask

  // Misaligned and out-of-range bases are rejected and leave memory untouched
  task automatic test_bad_base();
    run_burst("misaligned", 32'h6, 1, 1'b1);
    run_burst("oor", 32'h80, 1, 1'b1);
    run_burst("oor_rand", $urandom | 32'h80, 1, 1'b1);
    for (int i = 0; i < DEPTH; i++) fetch_q.push_back(32'(i) * 4);
    fetch_seq("bad_base_sweep");
  endtask

  // Burst running off the end of memory without load_last
  task automatic test_overflow();
    for (int i = 0; i < 3; i++) burst_data[i] = $urandom;
    run_burst("overflow", 32'h78, 3, 1'b0);
    fetch_q.push_back(32'h78);
    fetch_q.push_back(32'h7C);
    fetch_q.push_back(32'h74);
    fetch_q.push_back(32'h0);
    fetch_seq("overflow");
  endtask

  // Misaligned and out-of-range fetches plus a random address mix
  task automatic test_fetch_fault();
    fetch_q.push_back(32'h2);
    fetch_q.push_back(32'h100);
    fetch_q.push_back(32'h1);
    fetch_q.push_back(32'h7C);
    fetch_q.push_back(32'h80);
    fetch_q.push_back(32'hFFFF_FFFC);
    for (int i = 0; i < 20; i++) fetch_q.push_back(rand_addr());
    fetch_seq("fault");
  endtask

  // Random bursts; some naturally hit the last word
  task automatic test_random_bursts();
    int n;
    for (int k = 0; k < 6; k++) begin
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) burst_data[i] = $urandom;
      run_burst("rand", 32'($urandom_range(0, DEPTH - 1)) * 4, n, 1'b1);
      for (int i = 0; i < 10; i++) fetch_q.push_back(rand_addr());
      fetch_seq("rand");
    end
    for (int i = 0; i < DEPTH; i++) fetch_q.push_back(32'(i) * 4);
    fetch_seq("rand_sweep");
  endtask

  // Reset in the middle of a burst wipes everything back to NOP
  task automatic test_reset_mid_load();
    burst_data[0] = $urandom;
    burst_data[1] = $urandom;
    run_burst("midload", 32'h20, 2, 1'b0);
    n_cmp++;
    if (ready0 !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL midload_in_load got ready=%b exp=1", ready0);
    end
    fetch_addr = 32'h20;
    @(negedge clock);
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({busy0, ready0, done0, err0, c_valid, r_valid, r_fault} !== 7'b1000000) begin
      n_fail++;
      $display("[TB] FAIL midload_reset_flags got=%b%b%b%b%b%b%b exp=1000000", busy0, ready0, done0, err0, c_valid, r_valid, r_fault);
    end
    n_cmp++;
    if ({c_instr, r_instr} !== {NOP, NOP}) begin
      n_fail++;
      $display("[TB] FAIL midload_reset_instr got=%h/%h exp=%h/%h", c_instr, r_instr, NOP, NOP);
    end
    @(negedge clock);
    reset = 1'b0;
    run_clear("midload");
    fetch_q.push_back(32'h20);
    fetch_q.push_back(32'h24);
    fetch_q.push_back(32'h8);
    fetch_q.push_back(32'h7C);
    fetch_seq("midload_nop");
  endtask

  // Test sequence
  initial begin
    $display("[TB] start");
    test_reset();
    test_load_basic();
    test_bad_base();
    test_overflow();
    test_fetch_fault();
    test_random_bursts();
    test_reset_mid_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
